// File: rtl/rf80386_icache.sv
// rtl/rf80386_icache.sv - direct-mapped 16-byte-line instruction cache with FTA fill port
// Presents 16 code bytes at csip from an even/odd bank pair so a straddling fetch reads both lines at once.

package rf80386_fta_pkg;
  typedef enum logic [3:0] {
    CMD_NONE  = 4'd0,
    CMD_LOAD  = 4'd1,
    CMD_STORE = 4'd2
  } fta_cmd_t;

  typedef struct packed {
    logic [5:0] core;
    logic [2:0] channel;
    logic [3:0] tranid;
  } fta_tid_t;

  typedef struct packed {
    logic         cyc;
    logic         stb;
    logic         we;
    fta_cmd_t     cmd;
    logic [15:0]  sel;
    logic [31:0]  adr;
    fta_tid_t     tid;
    logic [127:0] dat;
  } fta_cmd_request128_t;

  typedef struct packed {
    logic         ack;
    logic         rty;
    fta_tid_t     tid;
    logic [127:0] dat;
  } fta_cmd_response128_t;
endpackage

module rf80386_icache
  import rf80386_fta_pkg::*;
#(
  parameter int         LINES   = 64,
  parameter logic [5:0] CORENO  = 6'd1,
  parameter logic [2:0] CID     = 3'd2,
  parameter logic [4:0] RTY_DLY = 5'd8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 invall_i,
  input  logic [31:0]          csip_i,
  output logic [127:0]         ibundle_o,
  output logic                 ihit_o,
  output fta_cmd_request128_t  ftam_req,
  input  fta_cmd_response128_t ftam_resp
);

  localparam int IW = $clog2(LINES);
  localparam int HL = LINES / 2;
  localparam int TW = 28 - IW;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RTYW} state_t;

  state_t        state;
  logic [27:0]   fadr;
  logic [3:0]    tid_cnt;
  logic [3:0]    itid;
  logic [4:0]    rty_cnt;
  logic          stale;

  logic [127:0]  data_e [HL];
  logic [127:0]  data_o [HL];
  logic [TW-1:0] tag_e  [HL];
  logic [TW-1:0] tag_o  [HL];
  logic [HL-1:0] valid_e;
  logic [HL-1:0] valid_o;

  logic [27:0]   lo_la;
  logic [IW-1:0] lo_idx;
  logic [TW-1:0] lo_tag;
  logic [TW-1:0] hi_tag;
  logic [IW-2:0] e_row;
  logic [IW-2:0] o_row;
  logic          e_match;
  logic          o_match;
  logic          lo_hit;
  logic          hi_hit;
  logic [127:0]  lo_line;
  logic [127:0]  hi_line;
  logic [255:0]  pair_shifted;

  assign lo_la  = csip_i[31:4];
  assign lo_idx = lo_la[IW-1:0];
  assign lo_tag = lo_la[27:IW];
  // The line after the last index belongs to the next tag.
  assign hi_tag = lo_tag + TW'(&lo_idx);
  assign o_row  = lo_idx[IW-1:1];
  assign e_row  = lo_idx[IW-1:1] + (IW-1)'(lo_idx[0]);

  assign e_match = valid_e[e_row] && (tag_e[e_row] == (lo_idx[0] ? hi_tag : lo_tag));
  assign o_match = valid_o[o_row] && (tag_o[o_row] == (lo_idx[0] ? lo_tag : hi_tag));
  assign lo_hit  = lo_idx[0] ? o_match : e_match;
  assign hi_hit  = lo_idx[0] ? e_match : o_match;
  assign lo_line = lo_idx[0] ? data_o[o_row] : data_e[e_row];
  assign hi_line = lo_idx[0] ? data_e[e_row] : data_o[o_row];

  assign pair_shifted = {hi_line, lo_line} >> {csip_i[3:0], 3'b000};
  assign ihit_o       = lo_hit & hi_hit & ~invall_i & (state == IDLE);
  assign ibundle_o    = ihit_o ? pair_shifted[127:0] : {16{8'h90}};

  logic [27:0]         f_la;
  logic [IW-2:0]       f_row;
  logic [TW-1:0]       f_tag;
  logic                rsp_match;
  logic                fill_we;
  logic [27:0]         issue_la;
  logic [3:0]          tid_next;
  fta_cmd_request128_t issue_req;

  assign f_la      = fadr;
  assign f_row     = f_la[IW-1:1];
  assign f_tag     = f_la[27:IW];
  assign rsp_match = (ftam_resp.tid == {CORENO, CID, itid});
  assign fill_we   = (state == WAIT) && ftam_resp.ack && rsp_match && !invall_i && !stale;
  assign tid_next  = (tid_cnt == 4'd15) ? 4'd1 : tid_cnt + 4'd1;
  assign issue_la  = (state == RTYW) ? fadr : (lo_hit ? lo_la + 28'd1 : lo_la);

  always_comb begin
    issue_req            = '0;
    issue_req.cyc        = 1'b1;
    issue_req.stb        = 1'b1;
    issue_req.cmd        = CMD_LOAD;
    issue_req.sel        = 16'hFFFF;
    issue_req.adr        = {issue_la, 4'h0};
    issue_req.tid.core   = CORENO;
    issue_req.tid.channel = CID;
    issue_req.tid.tranid = tid_cnt;
  end

  always_ff @(posedge clk_i) begin
    if (fill_we) begin
      if (f_la[0]) begin
        data_o[f_row] <= ftam_resp.dat;
        tag_o[f_row]  <= f_tag;
      end else begin
        data_e[f_row] <= ftam_resp.dat;
        tag_e[f_row]  <= f_tag;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      ftam_req <= '0;
      fadr     <= '0;
      tid_cnt  <= 4'd1;
      itid     <= '0;
      rty_cnt  <= '0;
      stale    <= 1'b0;
      valid_e  <= '0;
      valid_o  <= '0;
    end else begin
      if (fill_we) begin
        if (f_la[0]) valid_o[f_row] <= 1'b1;
        else         valid_e[f_row] <= 1'b1;
      end
      if (invall_i) begin
        valid_e <= '0;
        valid_o <= '0;
      end
      case (state)
        IDLE: begin
          if (!lo_hit || !hi_hit) begin
            ftam_req <= issue_req;
            fadr     <= issue_la;
            itid     <= tid_cnt;
            tid_cnt  <= tid_next;
            stale    <= 1'b0;
            state    <= REQ;
          end
        end
        REQ: begin
          ftam_req <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (invall_i) begin
            stale <= 1'b1;
            state <= IDLE;
          end else if (ftam_resp.ack && rsp_match) begin
            state <= IDLE;
          end else if (ftam_resp.rty && rsp_match) begin
            rty_cnt <= RTY_DLY;
            state   <= RTYW;
          end
        end
        RTYW: begin
          if (invall_i) begin
            stale <= 1'b1;
            state <= IDLE;
          end else if (rty_cnt == 5'd0) begin
            ftam_req <= issue_req;
            itid     <= tid_cnt;
            tid_cnt  <= tid_next;
            stale    <= 1'b0;
            state    <= REQ;
          end else begin
            rty_cnt <= rty_cnt - 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf80386_icache.sv
// tb/tb_rf80386_icache.sv - self-checking bench for rf80386_icache
// Memory is a byte function of address; the cache model tracks which line address each index holds.

module tb_rf80386_icache;
  import rf80386_fta_pkg::*;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 invall_i;
  logic [31:0]          csip_i;
  logic [127:0]         ibundle_o;
  logic                 ihit_o;
  fta_cmd_request128_t  ftam_req;
  fta_cmd_response128_t ftam_resp;

  always #5 clk_i = ~clk_i;

  rf80386_icache #(.LINES(64), .CORENO(6'd1), .CID(3'd2), .RTY_DLY(5'd8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .invall_i(invall_i), .csip_i(csip_i),
    .ibundle_o(ibundle_o), .ihit_o(ihit_o), .ftam_req(ftam_req), .ftam_resp(ftam_resp)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] m_line [64];
  bit          m_v [64];
  logic [3:0]  exp_tid;
  logic [7:0]  seed;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] p;
    p = a[7:0] * 8'd37;
    return p ^ a[15:8] ^ a[23:16] ^ seed;
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    logic [127:0] l;
    for (int i = 0; i < 16; i++) l[i*8 +: 8] = mem_byte(a + 32'(i));
    return l;
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_v[a[9:4]] && (m_line[a[9:4]] == a);
  endfunction

  function automatic void m_fill(input logic [31:0] a);
    m_v[a[9:4]] = 1'b1;
    m_line[a[9:4]] = a;
  endfunction

  function automatic void m_inval();
    for (int i = 0; i < 64; i++) m_v[i] = 1'b0;
  endfunction

  function automatic logic [3:0] next_tid(input logic [3:0] t);
    return (t == 4'd15) ? 4'd1 : t + 4'd1;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_req(output bit ok, output logic [31:0] adr, output logic [3:0] tid);
    ok = 1'b0; adr = 'x; tid = 'x;
    for (int i = 0; i < 40; i++) begin
      if (ftam_req.cyc && ftam_req.stb) begin
        ok = 1'b1; adr = ftam_req.adr; tid = ftam_req.tid.tranid;
        break;
      end
      step();
    end
  endtask

  task automatic respond(input logic [3:0] tid, input logic [31:0] adr, input bit rty, input int dly);
    repeat (1 + dly) step();
    ftam_resp.ack = !rty;
    ftam_resp.rty = rty;
    ftam_resp.tid.core = 6'd1;
    ftam_resp.tid.channel = 3'd2;
    ftam_resp.tid.tranid = tid;
    ftam_resp.dat = rty ? 128'd0 : mem_line(adr);
    step();
    ftam_resp = '0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; invall_i = 1'b0; ftam_resp = '0; csip_i = 32'h000F0000;
    m_inval(); exp_tid = 4'd1;
    repeat (3) step();
    n_checks++;
    if (ftam_req !== '0 || ihit_o !== 1'b0 || ibundle_o !== {16{8'h90}})
      $display("FAIL reset: req=%h ihit=%b bundle=%h required req=0 ihit=0 bundle=nops", ftam_req, ihit_o, ibundle_o);
    else n_pass++;
    rst_i = 1'b1;
  endtask

  task automatic test_cold_miss();
    bit ok; logic [31:0] a; logic [3:0] t;
    for (int f = 0; f < 2; f++) begin
      wait_req(ok, a, t);
      n_checks++;
      if (!ok || a !== 32'h000F0000 + 32'(f * 16) || t !== exp_tid || ftam_req.we !== 1'b0 ||
          ftam_req.cmd !== CMD_LOAD || ftam_req.sel !== 16'hFFFF || ftam_req.tid.core !== 6'd1 ||
          ftam_req.tid.channel !== 3'd2)
        $display("FAIL cold_req%0d: ok=%0b adr=%h tid=%0d we=%b cmd=%0d sel=%h required adr=%h tid=%0d load", f, ok, a, t,
                 ftam_req.we, ftam_req.cmd, ftam_req.sel, 32'h000F0000 + 32'(f * 16), exp_tid);
      else n_pass++;
      exp_tid = next_tid(exp_tid);
      respond(t, a, 1'b0, f);
      m_fill(32'h000F0000 + 32'(f * 16));
    end
    n_checks++;
    if (ihit_o !== 1'b1 || ibundle_o !== mem_line(csip_i))
      $display("FAIL cold_hit: ihit=%b bundle=%h required ihit=1 bundle=%h", ihit_o, ibundle_o, mem_line(csip_i));
    else n_pass++;
  endtask

  task automatic test_straddle();
    int bus = 0;
    logic [127:0] want;
    csip_i = 32'h000F000C; #1;
    for (int i = 0; i < 16; i++) want[i*8 +: 8] = mem_byte(32'h000F000C + 32'(i));
    n_checks++;
    if (ihit_o !== 1'b1 || ibundle_o !== want)
      $display("FAIL straddle: ihit=%b bundle=%h required ihit=1 bundle=%h", ihit_o, ibundle_o, want);
    else n_pass++;
    repeat (6) begin if (ftam_req.cyc) bus++; step(); end
    n_checks++;
    if (bus != 0) $display("FAIL straddle_quiet: bus cycles=%0d required 0", bus);
    else n_pass++;
  endtask

  task automatic test_alias();
    bit ok; logic [31:0] a; logic [3:0] t;
    logic [31:0] base [2] = '{32'h000F0400, 32'h000F0000};
    for (int b = 0; b < 2; b++) begin
      csip_i = base[b]; #1;
      n_checks++;
      if (ihit_o !== 1'b0) $display("FAIL alias_miss%0d: ihit=%b required 0", b, ihit_o);
      else n_pass++;
      for (int f = 0; f < 2; f++) begin
        wait_req(ok, a, t);
        n_checks++;
        if (!ok || a !== base[b] + 32'(f * 16) || t !== exp_tid)
          $display("FAIL alias_req%0d%0d: ok=%0b adr=%h tid=%0d required adr=%h tid=%0d", b, f, ok, a, t,
                   base[b] + 32'(f * 16), exp_tid);
        else n_pass++;
        exp_tid = next_tid(exp_tid);
        respond(t, a, 1'b0, 0);
        m_fill(base[b] + 32'(f * 16));
      end
    end
  endtask

  task automatic test_retry();
    bit ok; logic [31:0] a; logic [3:0] t;
    int stb_seen = 0;
    csip_i = 32'h00100020; #1;
    wait_req(ok, a, t);
    n_checks++;
    if (!ok || a !== 32'h00100020 || t !== exp_tid)
      $display("FAIL rty_first: ok=%0b adr=%h tid=%0d required adr=00100020 tid=%0d", ok, a, t, exp_tid);
    else n_pass++;
    exp_tid = next_tid(exp_tid);
    respond(t, a, 1'b1, 0);
    repeat (8) begin if (ftam_req.stb) stb_seen++; step(); end
    n_checks++;
    if (stb_seen != 0) $display("FAIL rty_quiet: stb cycles=%0d required 0", stb_seen);
    else n_pass++;
    for (int f = 0; f < 2; f++) begin
      wait_req(ok, a, t);
      n_checks++;
      if (!ok || a !== 32'h00100020 + 32'(f * 16) || t !== exp_tid)
        $display("FAIL rty_req%0d: ok=%0b adr=%h tid=%0d required adr=%h tid=%0d", f, ok, a, t,
                 32'h00100020 + 32'(f * 16), exp_tid);
      else n_pass++;
      exp_tid = next_tid(exp_tid);
      respond(t, a, 1'b0, 1);
      m_fill(32'h00100020 + 32'(f * 16));
    end
    n_checks++;
    if (ihit_o !== 1'b1 || ibundle_o !== mem_line(csip_i))
      $display("FAIL rty_hit: ihit=%b bundle=%h required ihit=1 bundle=%h", ihit_o, ibundle_o, mem_line(csip_i));
    else n_pass++;
  endtask

  task automatic test_invall();
    bit ok; logic [31:0] a; logic [3:0] t;
    logic [3:0] t_old;
    csip_i = 32'h00200040; #1;
    wait_req(ok, a, t_old);
    exp_tid = next_tid(exp_tid);
    step();
    invall_i = 1'b1; step(); invall_i = 1'b0;
    m_inval();
    ftam_resp.ack = 1'b1; ftam_resp.tid.core = 6'd1; ftam_resp.tid.channel = 3'd2;
    ftam_resp.tid.tranid = t_old; ftam_resp.dat = mem_line(32'h00200040);
    step(); ftam_resp = '0;
    wait_req(ok, a, t);
    n_checks++;
    if (!ok || a !== 32'h00200040 || t !== exp_tid)
      $display("FAIL invall_reissue: ok=%0b adr=%h tid=%0d required adr=00200040 tid=%0d", ok, a, t, exp_tid);
    else n_pass++;
    exp_tid = next_tid(exp_tid);
    step();
    ftam_resp.ack = 1'b1; ftam_resp.tid.core = 6'd1; ftam_resp.tid.channel = 3'd2;
    ftam_resp.tid.tranid = t; ftam_resp.dat = mem_line(32'h00200040);
    invall_i = 1'b1;
    step(); ftam_resp = '0; invall_i = 1'b0;
    n_checks++;
    if (ihit_o !== 1'b0) $display("FAIL invall_ack_hit: ihit=%b required 0", ihit_o);
    else n_pass++;
    for (int f = 0; f < 2; f++) begin
      wait_req(ok, a, t);
      n_checks++;
      if (!ok || a !== 32'h00200040 + 32'(f * 16) || t !== exp_tid)
        $display("FAIL invall_req%0d: ok=%0b adr=%h tid=%0d required adr=%h tid=%0d", f, ok, a, t,
                 32'h00200040 + 32'(f * 16), exp_tid);
      else n_pass++;
      exp_tid = next_tid(exp_tid);
      respond(t, a, 1'b0, 0);
      m_fill(32'h00200040 + 32'(f * 16));
    end
    n_checks++;
    if (ihit_o !== 1'b1) $display("FAIL invall_refill: ihit=%b required 1", ihit_o);
    else n_pass++;
  endtask

  task automatic test_random();
    bit ok; logic [31:0] a; logic [3:0] t;
    logic [31:0] lo_a, exp_a;
    for (int it = 0; it < 16; it++) begin
      csip_i = 32'h000F0000 + $urandom_range(0, 32'h7FF); #1;
      for (int r = 0; r < 3; r++) begin
        lo_a = {csip_i[31:4], 4'h0};
        if (m_hit(lo_a) && m_hit(lo_a + 32'd16)) break;
        exp_a = m_hit(lo_a) ? lo_a + 32'd16 : lo_a;
        wait_req(ok, a, t);
        n_checks++;
        if (!ok || a !== exp_a || t !== exp_tid)
          $display("FAIL rand_req%0d: csip=%h ok=%0b adr=%h tid=%0d required adr=%h tid=%0d", it, csip_i, ok, a, t,
                   exp_a, exp_tid);
        else n_pass++;
        exp_tid = next_tid(exp_tid);
        respond(t, exp_a, 1'b0, $urandom_range(0, 2));
        m_fill(exp_a);
      end
      n_checks++;
      if (ihit_o !== 1'b1 || ibundle_o !== mem_line(csip_i))
        $display("FAIL rand_hit%0d: csip=%h ihit=%b bundle=%h required ihit=1 bundle=%h", it, csip_i, ihit_o,
                 ibundle_o, mem_line(csip_i));
      else n_pass++;
    end
  endtask

  task automatic test_wrap_and_reset();
    bit ok; logic [31:0] a; logic [3:0] t;
    logic [3:0] t_old;
    bit saw_wrap = 1'b0;
    for (int k = 0; k < 8; k++) begin
      csip_i = 32'h00300000 + 32'(k * 32) + 32'(k); #1;
      for (int f = 0; f < 2; f++) begin
        wait_req(ok, a, t);
        n_checks++;
        if (!ok || a !== 32'h00300000 + 32'(k * 32 + f * 16) || t !== exp_tid)
          $display("FAIL wrap_req%0d%0d: ok=%0b adr=%h tid=%0d required adr=%h tid=%0d", k, f, ok, a, t,
                   32'h00300000 + 32'(k * 32 + f * 16), exp_tid);
        else n_pass++;
        if (exp_tid == 4'd1 && (k != 0 || f != 0)) saw_wrap = (t === 4'd1);
        exp_tid = next_tid(exp_tid);
        respond(t, a, 1'b0, 0);
        m_fill(32'h00300000 + 32'(k * 32 + f * 16));
      end
    end
    n_checks++;
    if (!saw_wrap) $display("FAIL wrap_seen: tranid 1 after 15 not observed, required observed");
    else n_pass++;
    csip_i = 32'h00400000; #1;
    wait_req(ok, a, t_old);
    step();
    rst_i = 1'b0; #1;
    n_checks++;
    if (ftam_req !== '0 || ihit_o !== 1'b0)
      $display("FAIL rst_mid_wait: req=%h ihit=%b required req=0 ihit=0", ftam_req, ihit_o);
    else n_pass++;
    step(); step();
    rst_i = 1'b1;
    m_inval(); exp_tid = 4'd1;
    wait_req(ok, a, t);
    n_checks++;
    if (!ok || a !== 32'h00400000 || t !== 4'd1)
      $display("FAIL rst_reissue: ok=%0b adr=%h tid=%0d required adr=00400000 tid=1", ok, a, t);
    else n_pass++;
    exp_tid = next_tid(exp_tid);
    if (t_old != 4'd1) respond(t_old, 32'h00400000, 1'b0, 0);
    respond(t, 32'h00400000, 1'b0, 0);
    wait_req(ok, a, t);
    n_checks++;
    if (!ok || a !== 32'h00400010 || t !== exp_tid)
      $display("FAIL rst_hi_req: ok=%0b adr=%h tid=%0d required adr=00400010 tid=%0d", ok, a, t, exp_tid);
    else n_pass++;
    respond(t, a, 1'b0, 0);
    n_checks++;
    if (ihit_o !== 1'b1 || ibundle_o !== mem_line(csip_i))
      $display("FAIL rst_hit: ihit=%b bundle=%h required ihit=1 bundle=%h", ihit_o, ibundle_o, mem_line(csip_i));
    else n_pass++;
  endtask

  initial begin
    seed = 8'($urandom);
    test_reset();
    test_cold_miss();
    test_straddle();
    test_alias();
    test_retry();
    test_invall();
    test_random();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
